// File: rtl/pipeline_stage_reg_pkg.sv
// Shared types for the generic valid/ready pipeline stage register.
// State encoding is {skid_v, main_v} so the valid bits fall straight out of the state.
package pipeline_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  // Source selected for the main (output-facing) entry on the next edge.
  typedef enum logic [1:0] {
    LD_NONE = 2'b00,
    LD_IN   = 2'b01,
    LD_SKID = 2'b10
  } main_sel_t;

  function automatic logic st_main_v(input state_t st);
    return st[0];
  endfunction

  function automatic logic st_skid_v(input state_t st);
    return st[1];
  endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Valid/ready stage register with optional 2-entry skid, flush and saturating stall counter.
// Latency 1 cycle when empty; SKID=1 gives a registered in_ready, SKID=0 a combinational one.
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit               SKID_EN = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  main_sel_t        main_sel;
  logic             skid_ld;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             main_v, skid_v;
  logic             in_xfer, out_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over everything; an input offered in a flush cycle is dropped.
  always_comb begin
    state_d  = state_q;
    main_sel = LD_NONE;
    skid_ld  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d  = ST_ONE;
            main_sel = LD_IN;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: main_sel = LD_IN;
            2'b10: begin
              state_d = ST_FULL;
              skid_ld = SKID_EN;
            end
            2'b01: state_d = ST_EMPTY;
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d  = ST_ONE;
            main_sel = LD_SKID;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // With the skid entry, in_ready comes straight from a flop; without it,
  // a full stage can still accept when the consumer drains it this cycle.
  always_comb begin
    main_v    = st_main_v(state_q);
    skid_v    = st_skid_v(state_q);
    out_valid = main_v;
    out_data  = main_q;
    stall_cnt = stall_q;
    if (SKID_EN) begin
      in_ready = !skid_v;
    end else begin
      in_ready = !main_v | out_ready;
    end
    in_xfer  = in_valid & in_ready;
    out_xfer = main_v & out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
    end else begin
      case (main_sel)
        LD_IN:   main_q <= in_data;
        LD_SKID: main_q <= skid_q;
        default: main_q <= main_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_q <= '0;
    end else if (skid_ld) begin
      skid_q <= in_data;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && !flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a skid instance and a single-entry CNT_W=2 instance,
// driven by a per-cycle vector table, hand sequences and a data-ordering scoreboard.
module tb_pipeline_stage_reg;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0] s_in_data, s_out_data;
  logic [15:0]  s_cnt;
  logic         n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [W-1:0] n_in_data, n_out_data;
  logic [1:0]   n_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] s_q[$];
  logic [W-1:0] n_q[$];

  pipeline_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .stall_cnt(s_cnt)
  );

  pipeline_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(2)) u_single (
    .clk(clk), .reset_n(reset_n), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .stall_cnt(n_cnt)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sample settled inputs/outputs mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      s_q.delete();
      n_q.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        if (s_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL skid_sb: unexpected output 0x%0h with nothing pending", s_out_data);
        end else begin
          check("skid_sb_order", s_out_data, s_q.pop_front());
        end
      end
      if (s_flush) s_q.delete();
      else if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);

      if (n_out_valid && n_out_ready) begin
        if (n_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL single_sb: unexpected output 0x%0h with nothing pending", n_out_data);
        end else begin
          check("single_sb_order", n_out_data, n_q.pop_front());
        end
      end
      if (n_flush) n_q.delete();
      else if (n_in_valid && n_in_ready) n_q.push_back(n_in_data);
      check("single_in_ready_comb", W'(n_in_ready), W'(!n_out_valid | n_out_ready));
    end
  end

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         eov;
    logic         chk_od;
    logic [W-1:0] eod;
    logic         eir;
    logic [15:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic ordy,
                              input logic fl, input logic eov, input logic chk_od,
                              input logic [W-1:0] eod, input logic eir, input logic [15:0] ecnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.eov = eov;
    v.chk_od = chk_od; v.eod = eod; v.eir = eir; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    // Stall-then-release, flush of FULL, flush on EMPTY, flush with out transfer.
    vecs[0]  = mk(1, 64'hA,  0, 0, 1, 1, 64'hA, 1, 0);
    vecs[1]  = mk(1, 64'hB,  0, 0, 1, 1, 64'hA, 0, 1);
    vecs[2]  = mk(0, 64'h0,  0, 0, 1, 1, 64'hA, 0, 2);
    vecs[3]  = mk(0, 64'h0,  1, 0, 1, 1, 64'hB, 1, 2);
    vecs[4]  = mk(0, 64'h0,  1, 0, 0, 0, 64'h0, 1, 2);
    vecs[5]  = mk(1, 64'hA,  0, 0, 1, 1, 64'hA, 1, 2);
    vecs[6]  = mk(1, 64'hB,  0, 0, 1, 1, 64'hA, 0, 3);
    vecs[7]  = mk(0, 64'h0,  0, 1, 0, 0, 64'h0, 1, 3);
    vecs[8]  = mk(1, 64'h55, 1, 1, 0, 0, 64'h0, 1, 3);
    vecs[9]  = mk(0, 64'h0,  1, 0, 0, 0, 64'h0, 1, 3);
    vecs[10] = mk(1, 64'hC,  1, 0, 1, 1, 64'hC, 1, 3);
    vecs[11] = mk(1, 64'hD,  1, 1, 0, 0, 64'h0, 1, 3);
    vecs[12] = mk(0, 64'h0,  1, 0, 0, 0, 64'h0, 1, 3);

    reset_n = 1'b0;
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
    n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 1;
    #1;
    check("rst_skid_out_valid", W'(s_out_valid), 0);
    check("rst_skid_out_data", s_out_data, 0);
    check("rst_skid_in_ready", W'(s_in_ready), 1);
    check("rst_skid_stall_cnt", W'(s_cnt), 0);
    check("rst_single_in_ready", W'(n_in_ready), 1);
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate streaming with one cycle of latency.
    for (int k = 1; k <= 8; k++) begin
      s_in_valid = 1; s_in_data = W'(k); s_out_ready = 1;
      @(posedge clk); #1;
      check("stream_out_valid", W'(s_out_valid), 1);
      check("stream_out_data", s_out_data, W'(k));
      check("stream_in_ready", W'(s_in_ready), 1);
    end
    s_in_valid = 0;
    @(posedge clk); #1;
    check("stream_drained", W'(s_out_valid), 0);
    check("stream_no_stall", W'(s_cnt), 0);

    for (int i = 0; i < 13; i++) begin
      s_in_valid = vecs[i].iv; s_in_data = vecs[i].id;
      s_out_ready = vecs[i].ordy; s_flush = vecs[i].fl;
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), W'(s_out_valid), W'(vecs[i].eov));
      check($sformatf("vec%0d_in_ready", i), W'(s_in_ready), W'(vecs[i].eir));
      check($sformatf("vec%0d_stall_cnt", i), W'(s_cnt), W'(vecs[i].ecnt));
      if (vecs[i].chk_od) check($sformatf("vec%0d_out_data", i), s_out_data, vecs[i].eod);
    end
    s_flush = 0; s_in_valid = 0;

    // Asynchronous reset landing between edges while the skid stage is full.
    s_in_valid = 1; s_in_data = 64'h77; s_out_ready = 0;
    @(posedge clk); #1;
    s_in_data = 64'h78;
    @(posedge clk); #1;
    s_in_valid = 0;
    check("pre_reset_full", W'(s_in_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", W'(s_out_valid), 0);
    check("async_rst_out_data", s_out_data, 0);
    check("async_rst_stall_cnt", W'(s_cnt), 0);
    check("async_rst_in_ready", W'(s_in_ready), 1);
    #4 reset_n = 1'b1;
    s_out_ready = 1;
    @(posedge clk); #1;
    check("post_rst_out_valid", W'(s_out_valid), 0);

    // Single-entry: counter saturation and combinational in_ready.
    n_in_valid = 1; n_in_data = 64'h900; n_out_ready = 0;
    @(posedge clk); #1;
    n_in_valid = 0;
    check("single_load_valid", W'(n_out_valid), 1);
    check("single_load_cnt", W'(n_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("single_sat_cnt%0d", k), W'(n_cnt), W'((k > 3) ? 3 : k));
    end
    check("single_full_in_ready_low", W'(n_in_ready), 0);
    n_out_ready = 1;
    #1;
    check("single_full_in_ready_follows", W'(n_in_ready), 1);
    check("single_data_stable", n_out_data, 64'h900);
    @(posedge clk); #1;

    for (int c = 0; c < 400; c++) begin
      n_in_valid  = ($urandom_range(0, 3) != 0);
      n_in_data   = {$urandom(), $urandom()};
      n_out_ready = ($urandom_range(0, 2) != 0);
      n_flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    n_flush = 0; n_in_valid = 0; n_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("single_drained", W'(n_q.size()), 0);
    check("single_cnt_saturated", W'(n_cnt), 3);
    check("skid_sb_empty", W'(s_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
